// File: rtl/pakout_ser_pkg.sv
// Shared types and sizing helpers for the message-to-packet serializer.
package pakout_ser_pkg;

    localparam int unsigned DEF_PSZ = 8;
    localparam int unsigned DEF_ASZ = 8;
    localparam int unsigned DEF_DSZ = 16;
    localparam int unsigned DEF_RSZ = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    // Packets needed to carry msz bits in psz-bit slices.
    function automatic int unsigned npk_of(input int unsigned msz, input int unsigned psz);
        return (msz + psz - 1) / psz;
    endfunction

    // Packet index width; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pakout_ser.sv
// Serializes one {src, dst, dat, red} message into NPK packets, MSB slice first,
// over 4-phase req/ack handshakes on both the message and packet sides.
module pakout_ser
    import pakout_ser_pkg::*;
#(
    parameter int unsigned PSZ = DEF_PSZ,
    parameter int unsigned ASZ = DEF_ASZ,
    parameter int unsigned DSZ = DEF_DSZ,
    parameter int unsigned RSZ = DEF_RSZ
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [ASZ-1:0]   i_src,
    input  logic [ASZ-1:0]   i_dst,
    input  logic [DSZ-1:0]   i_dat,
    input  logic [RSZ-1:0]   i_red,
    input  logic             i_req,
    output logic             o_ack,
    output logic [PSZ-1:0]   o_pak,
    output logic             o_first,
    output logic             o_req,
    input  logic             i_ack,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_msg_cnt
);

    localparam int unsigned MSZ = 2 * ASZ + DSZ + RSZ;
    localparam int unsigned NPK = npk_of(MSZ, PSZ);
    localparam int unsigned WSZ = NPK * PSZ;
    localparam int unsigned PAD = WSZ - MSZ;
    localparam int unsigned IW  = idx_w(NPK);
    localparam logic [IW-1:0] IDX_LAST = IW'(NPK - 1);

    state_t             state_q, state_d;
    logic [WSZ-1:0]     word_q, word_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               ack_q, ack_d;
    logic               req_q, req_d;
    logic               first_q, first_d;
    logic               busy_q, busy_d;
    logic [PSZ-1:0]     pak_q, pak_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WSZ-1:0]     load_w;

    // Message left-justified in the shift word, zero padding at the LSB end.
    assign load_w = WSZ'({i_src, i_dst, i_dat, i_red}) << PAD;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            pak_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            pak_q   <= pak_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        ack_d   = ack_q;
        req_d   = req_q;
        first_d = first_q;
        busy_d  = busy_q;
        pak_d   = pak_q;
        cnt_d   = cnt_q;

        // Message-side release runs independently of packet progress.
        if (ack_q && !i_req) begin
            ack_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_req && !ack_q && !i_ack) begin
                    word_d  = load_w;
                    idx_d   = '0;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    first_d = 1'b1;
                    pak_d   = load_w[WSZ-1 -: PSZ];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!i_ack) begin
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        word_d  = word_q << PSZ;
                        pak_d   = word_d[WSZ-1 -: PSZ];
                        first_d = 1'b0;
                        req_d   = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_ack     = ack_q;
    assign o_req     = req_q;
    assign o_first   = first_q;
    assign o_busy    = busy_q;
    assign o_pak     = pak_q;
    assign o_msg_cnt = cnt_q;

endmodule

// File: tb/tb_pakout_ser.sv
// Scoreboard bench for pakout_ser: PSZ=4 main instance with a 1-cycle responder,
// plus a PSZ=8 instance for the zero-padded slicing case.
module tb_pakout_ser;

    localparam int TMO = 400;
    localparam int NPK = 5;

    logic       clk;
    logic       rst_n;
    logic [5:0] src, dst;
    logic [3:0] dat, red;

    logic       req4, ack4, o_ack4, o_first4, o_req4, o_busy4;
    logic [3:0] o_pak4;
    logic [7:0] o_cnt4;

    logic       req8, ack8, o_ack8, o_first8, o_req8, o_busy8;
    logic [7:0] o_pak8;
    logic [7:0] o_cnt8;

    int         n_chk, n_pass;
    logic [7:0] exp_cnt;
    logic [8:0] q4[$];
    logic [8:0] q8[$];

    bit         force_hi;
    int         stall_idx, stall_len;
    int         mon_idx;

    pakout_ser #(.PSZ(4), .ASZ(6), .DSZ(4), .RSZ(4)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_src(src), .i_dst(dst), .i_dat(dat), .i_red(red),
        .i_req(req4), .o_ack(o_ack4),
        .o_pak(o_pak4), .o_first(o_first4), .o_req(o_req4), .i_ack(ack4),
        .o_busy(o_busy4), .o_msg_cnt(o_cnt4)
    );

    pakout_ser #(.PSZ(8), .ASZ(6), .DSZ(4), .RSZ(4)) u_dut8 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_src(src), .i_dst(dst), .i_dat(dat), .i_red(red),
        .i_req(req8), .o_ack(o_ack8),
        .o_pak(o_pak8), .o_first(o_first8), .o_req(o_req8), .i_ack(ack8),
        .o_busy(o_busy8), .o_msg_cnt(o_cnt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference slicer: message left-justified in NPK*psz bits, slice k from the top.
    function automatic logic [7:0] model_pak(input logic [5:0] s, input logic [5:0] d,
                                             input logic [3:0] da, input logic [3:0] r,
                                             input int psz, input int k);
        logic [63:0] w;
        int npk, wsz;
        npk = (20 + psz - 1) / psz;
        wsz = npk * psz;
        w = {44'd0, s, d, da, r};
        w = w << (wsz - 20);
        w = (w >> (wsz - psz * (k + 1))) & ((64'd1 << psz) - 64'd1);
        return w[7:0];
    endfunction

    // Responder for the PSZ=4 instance: ack one cycle after req, optional stall on one packet.
    initial begin
        int  rsp_idx, stall_left;
        bit  rsp_prev;
        ack4 = 1'b0; rsp_idx = 0; stall_left = 0; rsp_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack4 = 1'b0; rsp_prev = 1'b0; stall_left = 0;
            end else if (force_hi) begin
                ack4 = 1'b1;
            end else begin
                if (o_req4 && !rsp_prev) begin
                    rsp_idx    = o_first4 ? 0 : rsp_idx + 1;
                    stall_left = (rsp_idx == stall_idx) ? stall_len : 0;
                end
                if (o_req4) begin
                    if (stall_left > 0) stall_left--;
                    else ack4 = 1'b1;
                end else begin
                    ack4 = 1'b0;
                end
                rsp_prev = o_req4;
            end
        end
    end

    // Packet monitor: pops expected packets on req rise, checks hold and req width.
    initial begin
        bit         mon_prev;
        int         mon_hi;
        logic [3:0] mon_pak;
        logic       mon_first;
        logic [8:0] e;
        mon_prev = 1'b0; mon_hi = 0; mon_idx = 0; mon_pak = '0; mon_first = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                q4.delete();
                mon_prev = 1'b0; mon_hi = 0;
            end else begin
                if (o_req4 && !mon_prev) begin
                    mon_idx = o_first4 ? 0 : mon_idx + 1;
                    if (q4.size() == 0) begin
                        check("pak_unexpected", 32'(o_pak4), 32'hFFFF_FFFF);
                    end else begin
                        e = q4.pop_front();
                        check("pak", 32'(o_pak4), 32'(e[3:0]));
                        check("first", 32'(o_first4), 32'(e[8]));
                    end
                    mon_pak = o_pak4; mon_first = o_first4; mon_hi = 1;
                end else if (o_req4) begin
                    check("pak_hold", 32'(o_pak4), 32'(mon_pak));
                    check("first_hold", 32'(o_first4), 32'(mon_first));
                    mon_hi++;
                end else if (mon_prev) begin
                    check("pak_hold_rel", 32'(o_pak4), 32'(mon_pak));
                    check("req_width", 32'(mon_hi), (mon_idx == stall_idx) ? 32'(1 + stall_len) : 32'd1);
                end
                mon_prev = o_req4;
            end
        end
    end

    task automatic send_msg(input logic [5:0] s, input logic [5:0] d, input logic [3:0] da,
                            input logic [3:0] r, input bit hold, input bit pre);
        int n;
        n = 0;
        @(negedge clk);
        while ((o_busy4 || o_ack4 || ack4 || o_req4) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("idle_timeout", 32'd0, 32'd1);
        src = s; dst = d; dat = da; red = r;
        if (!pre) begin
            for (int k = 0; k < NPK; k++) q4.push_back({(k == 0), model_pak(s, d, da, r, 4, k)});
        end
        req4 = 1'b1;
        @(posedge clk); #1;
        check("acc_ack", 32'(o_ack4), 32'd1);
        check("acc_busy", 32'(o_busy4), 32'd1);
        check("acc_first", 32'(o_first4), 32'd1);
        exp_cnt++;
        if (!hold) begin
            @(negedge clk);
            req4 = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((o_busy4 || q4.size() != 0) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("done_timeout", 32'd0, 32'd1);
        check("msg_cnt", 32'(o_cnt4), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] e;
        int         n;
        n_chk = 0; n_pass = 0; exp_cnt = '0;
        rst_n = 1'b0; req4 = 1'b0; req8 = 1'b0; ack8 = 1'b0;
        src = '0; dst = '0; dat = '0; red = '0;
        force_hi = 1'b0; stall_idx = -1; stall_len = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(o_ack4), 32'd0);
        check("rst_req", 32'(o_req4), 32'd0);
        check("rst_first", 32'(o_first4), 32'd0);
        check("rst_busy", 32'(o_busy4), 32'd0);
        check("rst_pak", 32'(o_pak4), 32'd0);
        check("rst_cnt", 32'(o_cnt4), 32'd0);
        check("rst_busy8", 32'(o_busy8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference message, expected slices written out directly.
        q4.push_back(9'h100); q4.push_back(9'h00C); q4.push_back(9'h001);
        q4.push_back(9'h005); q4.push_back(9'h00F);
        send_msg(6'd3, 6'd1, 4'd5, 4'd15, 1'b0, 1'b1);
        wait_done();

        // Same message through the 8-bit packet instance, last slice zero padded.
        q8.push_back(9'h10C); q8.push_back(9'h015); q8.push_back(9'h0F0);
        @(negedge clk);
        req8 = 1'b1;
        @(posedge clk); #1;
        check("acc8_ack", 32'(o_ack8), 32'd1);
        check("acc8_busy", 32'(o_busy8), 32'd1);
        @(negedge clk);
        req8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!o_req8 && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) check("req8_timeout", 32'd0, 32'd1);
            e = q8.pop_front();
            check("pak8", 32'(o_pak8), 32'(e[7:0]));
            check("first8", 32'(o_first8), 32'(e[8]));
            @(negedge clk);
            ack8 = 1'b1;
            n = 0;
            while (o_req8 && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) check("rel8_timeout", 32'd0, 32'd1);
            check("pak8_hold_rel", 32'(o_pak8), 32'(e[7:0]));
            ack8 = 1'b0;
        end
        n = 0;
        while (o_busy8 && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("busy8_timeout", 32'd0, 32'd1);
        check("msg_cnt8", 32'(o_cnt8), 32'd1);

        // Message request held high: one message only, ack stays up until req drops.
        send_msg(6'h2A, 6'h15, 4'h9, 4'h6, 1'b1, 1'b0);
        wait_done();
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_ack", 32'(o_ack4), 32'd1);
            check("hold_busy", 32'(o_busy4), 32'd0);
            check("hold_req", 32'(o_req4), 32'd0);
        end
        @(negedge clk);
        req4 = 1'b0;
        @(posedge clk); #1;
        check("hold_ack_drop", 32'(o_ack4), 32'd0);

        // Responder stalls packet 2 for 10 cycles.
        stall_idx = 2; stall_len = 10;
        send_msg(6'h11, 6'h3E, 4'hA, 4'h1, 1'b0, 1'b0);
        wait_done();
        stall_idx = -1; stall_len = 0;

        // Packet ack already high in IDLE blocks acceptance.
        @(posedge clk); #1;
        force_hi = 1'b1;
        @(negedge clk);
        src = 6'h05; dst = 6'h30; dat = 4'h7; red = 4'hC;
        for (int k = 0; k < NPK; k++) q4.push_back({(k == 0), model_pak(6'h05, 6'h30, 4'h7, 4'hC, 4, k)});
        req4 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("blk_ack", 32'(o_ack4), 32'd0);
            check("blk_busy", 32'(o_busy4), 32'd0);
        end
        force_hi = 1'b0;
        @(posedge clk); #1;
        check("unblk_ack", 32'(o_ack4), 32'd1);
        exp_cnt++;
        @(negedge clk);
        req4 = 1'b0;
        wait_done();

        // Reset while packet 3 is on the link, then a clean message from packet 0.
        send_msg(6'h3F, 6'h00, 4'h3, 4'h8, 1'b0, 1'b0);
        n = 0;
        while (!(o_req4 && mon_idx == 3) && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) check("pk3_timeout", 32'd0, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ack", 32'(o_ack4), 32'd0);
        check("mid_rst_req", 32'(o_req4), 32'd0);
        check("mid_rst_first", 32'(o_first4), 32'd0);
        check("mid_rst_busy", 32'(o_busy4), 32'd0);
        check("mid_rst_pak", 32'(o_pak4), 32'd0);
        check("mid_rst_cnt", 32'(o_cnt4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        send_msg(6'h12, 6'h34, 4'h5, 4'h6, 1'b0, 1'b0);
        wait_done();

        // Back-to-back traffic until the message counter wraps.
        for (int i = 0; i < 255; i++) begin
            send_msg(6'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            wait_done();
        end
        check("cnt_wrap", 32'(o_cnt4), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
